// File: rtl/rst_pkg.sv
// rtl/rst_pkg.sv - shared state and path encodings for the reset sequencer
package rst_pkg;

   typedef enum logic [2:0] {
      PWR_HOLD = 3'd0,
      STEP     = 3'd1,
      RUN      = 3'd2,
      SW_HOLD  = 3'd3,
      DONE     = 3'd4
   } rst_state_t;

   // Selects where STEP goes after the last release: RUN after power-on, DONE after a software request
   typedef enum logic {
      PATH_PWR = 1'b0,
      PATH_SW  = 1'b1
   } rst_path_t;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rst_delay_cnt.sv
// rtl/rst_delay_cnt.sv - saturating delay counter shared by the hold and step waits
module rst_delay_cnt #(
   parameter int CNT_W        = 8,
   parameter int RESET_TARGET = 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             CLR,
   input  logic             EN,
   input  logic             LOAD,
   input  logic [CNT_W-1:0] TARGET,
   output logic             DONE
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] tgt;

   // DONE marks the last cycle of a TARGET-cycle wait; the count stops there instead of wrapping
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt <= '0;
         tgt <= CNT_W'(RESET_TARGET);
      end else if (LOAD) begin
         cnt <= '0;
         tgt <= TARGET;
      end else if (CLR) begin
         cnt <= '0;
      end else if (EN && !DONE) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign DONE = (cnt == tgt - 1'b1);

endmodule

// File: rtl/rst_sequencer.sv
// rtl/rst_sequencer.sv - power-on and software reset sequencer for downstream clock domains
module rst_sequencer
   import rst_pkg::*;
#(
   parameter int NUM_DOMAINS = 4,
   parameter int HOLD_CYCLES = 16,
   parameter int STEP_CYCLES = 8,
   parameter int CNT_W       = 8
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   SW_RST_REQ,
   input  logic [NUM_DOMAINS-1:0] DOMAIN_MASK,
   output logic [NUM_DOMAINS-1:0] DOMAIN_RST_N,
   output logic                   SW_RST_ACK,
   output logic                   BUSY,
   output logic                   ALL_READY
);

   localparam int IDX_W = idx_width(NUM_DOMAINS);

   rst_state_t             state;
   rst_path_t              path;
   logic [IDX_W-1:0]       idx;
   logic [IDX_W-1:0]       nxt_idx;
   logic [IDX_W-1:0]       low_idx;
   logic                   nxt_found;
   logic [NUM_DOMAINS-1:0] cmask;
   logic [NUM_DOMAINS-1:0] dom_q;
   logic [NUM_DOMAINS-1:0] dom_rel;
   logic                   ack_q;
   logic                   busy_q;
   logic                   ready_q;
   logic                   cnt_done;
   logic                   cnt_clr;
   logic                   cnt_en;
   logic                   cnt_load;
   logic [CNT_W-1:0]       cnt_tgt;

   // Lowest set bit of the captured mask, and the next set bit above the current index
   always_comb begin
      nxt_found = 1'b0;
      nxt_idx   = idx;
      low_idx   = '0;
      for (int i = NUM_DOMAINS - 1; i >= 0; i--) begin
         if (cmask[i]) begin
            low_idx = IDX_W'(i);
         end
         if (cmask[i] && (i > int'(idx))) begin
            nxt_found = 1'b1;
            nxt_idx   = IDX_W'(i);
         end
      end
      dom_rel      = dom_q;
      dom_rel[idx] = 1'b1;
   end

   always_comb begin
      cnt_clr  = 1'b0;
      cnt_en   = 1'b0;
      cnt_load = 1'b0;
      cnt_tgt  = CNT_W'(HOLD_CYCLES);
      case (state)
         PWR_HOLD, SW_HOLD: begin
            cnt_en = 1'b1;
            if (cnt_done) begin
               cnt_load = 1'b1;
               cnt_tgt  = CNT_W'(STEP_CYCLES);
            end
         end
         STEP: begin
            if (!nxt_found) begin
               cnt_clr = 1'b1;
            end else if (cnt_done) begin
               cnt_load = 1'b1;
               cnt_tgt  = CNT_W'(STEP_CYCLES);
            end else begin
               cnt_en = 1'b1;
            end
         end
         RUN: begin
            if (SW_RST_REQ) begin
               cnt_load = 1'b1;
            end else begin
               cnt_clr = 1'b1;
            end
         end
         default: cnt_clr = 1'b1;
      endcase
   end

   rst_delay_cnt #(
      .CNT_W       (CNT_W),
      .RESET_TARGET(HOLD_CYCLES)
   ) u_delay_cnt (
      .CLK   (CLK),
      .RST   (RST),
      .CLR   (cnt_clr),
      .EN    (cnt_en),
      .LOAD  (cnt_load),
      .TARGET(cnt_tgt),
      .DONE  (cnt_done)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state   <= PWR_HOLD;
         path    <= PATH_PWR;
         idx     <= '0;
         cmask   <= '1;
         dom_q   <= '0;
         ack_q   <= 1'b0;
         busy_q  <= 1'b1;
         ready_q <= 1'b0;
      end else begin
         ack_q <= 1'b0;
         case (state)
            PWR_HOLD: begin
               if (cnt_done) begin
                  state <= STEP;
                  idx   <= low_idx;
               end
            end
            STEP: begin
               dom_q   <= dom_rel;
               ready_q <= &dom_rel;
               if (!nxt_found) begin
                  if (path == PATH_SW) begin
                     state <= DONE;
                  end else begin
                     state  <= RUN;
                     busy_q <= 1'b0;
                  end
               end else if (cnt_done) begin
                  idx <= nxt_idx;
               end
            end
            RUN: begin
               busy_q <= SW_RST_REQ;
               if (SW_RST_REQ) begin
                  cmask <= DOMAIN_MASK;
                  path  <= PATH_SW;
                  state <= (DOMAIN_MASK == '0) ? DONE : SW_HOLD;
               end
            end
            SW_HOLD: begin
               dom_q   <= dom_q & ~cmask;
               ready_q <= &(dom_q & ~cmask);
               if (cnt_done) begin
                  state <= STEP;
                  idx   <= low_idx;
               end
            end
            DONE: begin
               // BUSY stays high through the ACK cycle and drops with it on the next RUN cycle
               ack_q <= 1'b1;
               state <= RUN;
            end
            default: state <= PWR_HOLD;
         endcase
      end
   end

   assign DOMAIN_RST_N = dom_q;
   assign SW_RST_ACK   = ack_q;
   assign BUSY         = busy_q;
   assign ALL_READY    = ready_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// tb/tb_rst_sequencer.sv - randomized bench for rst_sequencer with a timeline-based reference model
module tb_rst_sequencer;

   localparam int N    = 4;
   localparam int HOLD = 16;
   localparam int STP  = 8;
   localparam int T_PO = HOLD + (N - 1) * STP;

   logic         CLK = 1'b0;
   logic         RST = 1'b1;
   logic         SW_RST_REQ = 1'b0;
   logic [N-1:0] DOMAIN_MASK = '0;
   logic [N-1:0] DOMAIN_RST_N;
   logic         SW_RST_ACK;
   logic         BUSY;
   logic         ALL_READY;

   int checks = 0;
   int errors = 0;

   rst_sequencer #(
      .NUM_DOMAINS(N),
      .HOLD_CYCLES(HOLD),
      .STEP_CYCLES(STP),
      .CNT_W      (8)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .SW_RST_REQ  (SW_RST_REQ),
      .DOMAIN_MASK (DOMAIN_MASK),
      .DOMAIN_RST_N(DOMAIN_RST_N),
      .SW_RST_ACK  (SW_RST_ACK),
      .BUSY        (BUSY),
      .ALL_READY   (ALL_READY)
   );

   always #5 CLK = ~CLK;

   // Reference: outputs as a function of edge number since reset release or since acceptance
   int           e = -1;
   int           phase = 0;
   int           acc_e = 0;
   int           ackd = 0;
   int           nrel = 0;
   int           dd = 0;
   int           rel_d[N];
   logic [N-1:0] m_mask = '0;
   logic [N-1:0] x_dom = '0;
   logic         x_ack = 1'b0;
   logic         x_busy = 1'b1;

   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         e = -1;
         phase = 0;
         x_dom = '0;
         x_ack = 1'b0;
         x_busy = 1'b1;
      end else begin
         e++;
         x_ack = 1'b0;
         if (phase == 0) begin
            for (int k = 0; k < N; k++)
               if (e == HOLD + k * STP) x_dom[k] = 1'b1;
            if (e == T_PO) begin
               x_busy = 1'b0;
               phase = 1;
            end
         end else if (phase == 1) begin
            x_busy = 1'b0;
            if (SW_RST_REQ) begin
               acc_e = e;
               m_mask = DOMAIN_MASK;
               nrel = 0;
               ackd = 1;
               for (int k = 0; k < N; k++) begin
                  if (m_mask[k]) begin
                     rel_d[k] = 1 + HOLD + nrel * STP;
                     ackd = rel_d[k] + 1;
                     nrel++;
                  end else begin
                     rel_d[k] = -1;
                  end
               end
               x_busy = 1'b1;
               phase = 2;
            end
         end else begin
            dd = e - acc_e;
            if (dd == 1) x_dom = x_dom & ~m_mask;
            for (int k = 0; k < N; k++)
               if (rel_d[k] == dd) x_dom[k] = 1'b1;
            if (dd == ackd) begin
               x_ack = 1'b1;
               phase = 1;
            end
         end
      end
   end

   always @(negedge CLK) begin
      checks++;
      if ({DOMAIN_RST_N, SW_RST_ACK, BUSY, ALL_READY} !== {x_dom, x_ack, x_busy, &x_dom}) begin
         errors++;
         $display("FAIL cycle e=%0d: got dom=%b ack=%b busy=%b ready=%b, want dom=%b ack=%b busy=%b ready=%b",
                  e, DOMAIN_RST_N, SW_RST_ACK, BUSY, ALL_READY, x_dom, x_ack, x_busy, &x_dom);
      end
   end

   int           rise[N];
   int           ack_e = -1;
   int           ack_cnt = 0;
   logic [N-1:0] prev_dom = '0;

   always @(negedge CLK) begin
      if (RST) begin
         for (int k = 0; k < N; k++) rise[k] = -1;
         prev_dom = '0;
      end else begin
         for (int k = 0; k < N; k++)
            if (DOMAIN_RST_N[k] && !prev_dom[k]) rise[k] = e;
         prev_dom = DOMAIN_RST_N;
         if (SW_RST_ACK) begin
            ack_e = e;
            ack_cnt++;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge CLK);
      #1;
   endtask

   task automatic go_to_edge(input int n);
      for (int i = 0; i < 2000 && e < n; i++) step();
      check("edge_reach", (e >= n), 1);
   endtask

   task automatic wait_ack();
      bit got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         step();
         if (SW_RST_ACK === 1'b1) got = 1'b1;
      end
      check("ack_wait", got, 1);
   endtask

   task automatic wait_idle();
      bit got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         step();
         if (BUSY === 1'b0) got = 1'b1;
      end
      check("idle_wait", got, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_dom"}, DOMAIN_RST_N, 0);
      check({tag, "_ack"}, SW_RST_ACK, 0);
      check({tag, "_busy"}, BUSY, 1);
      check({tag, "_ready"}, ALL_READY, 0);
   endtask

   task automatic check_po_rises(input string tag);
      for (int k = 0; k < N; k++)
         check($sformatf("%s_rise%0d", tag, k), rise[k], 16 + 8 * k);
   endtask

   int a0;
   int busy_n;
   int ack_before;

   initial begin
      repeat (3) step();
      check_reset_outputs("rst");

      // Request held through power-on; mask changes before the first RUN cycle
      SW_RST_REQ = 1'b1;
      DOMAIN_MASK = 4'b0110;
      RST = 1'b0;
      go_to_edge(30);
      DOMAIN_MASK = 4'b1010;
      go_to_edge(39);
      check("po39_busy", BUSY, 1);
      check("po39_ready", ALL_READY, 0);
      go_to_edge(40);
      check("po40_busy", BUSY, 0);
      check("po40_ready", ALL_READY, 1);
      check_po_rises("po");
      wait_ack();
      SW_RST_REQ = 1'b0;
      check("m1010_ack_edge", ack_e, 67);
      check("m1010_rise1", rise[1], 58);
      check("m1010_rise3", rise[3], 66);
      check("m1010_rise0", rise[0], 16);
      check("m1010_rise2", rise[2], 32);

      // Zero mask
      step();
      SW_RST_REQ = 1'b1;
      DOMAIN_MASK = '0;
      a0 = e + 1;
      step();
      SW_RST_REQ = 1'b0;
      busy_n = int'(BUSY);
      repeat (4) begin
         step();
         busy_n += int'(BUSY);
      end
      check("zero_busy_cycles", busy_n, 2);
      check("zero_ack_edge", ack_e, a0 + 1);
      check("zero_dom", DOMAIN_RST_N, 4'hF);

      // Handshaked random requests, sometimes held one extra cycle for a back-to-back sequence
      for (int it = 0; it < 12; it++) begin
         repeat ($urandom_range(0, 4)) step();
         SW_RST_REQ = 1'b1;
         DOMAIN_MASK = N'($urandom);
         wait_ack();
         if ($urandom_range(0, 2) == 0) step();
         SW_RST_REQ = 1'b0;
         wait_idle();
      end

      // Free-running random request/mask traffic
      for (int i = 0; i < 500; i++) begin
         step();
         SW_RST_REQ = ($urandom_range(0, 5) == 0);
         DOMAIN_MASK = N'($urandom);
      end
      SW_RST_REQ = 1'b0;
      wait_idle();

      // Reset pulse at edge 28 of power-on
      step();
      RST = 1'b1;
      repeat (2) step();
      RST = 1'b0;
      go_to_edge(28);
      check("pre_rst_dom", DOMAIN_RST_N, 4'b0011);
      RST = 1'b1;
      #1;
      check_reset_outputs("rst28");
      repeat (2) step();
      RST = 1'b0;
      go_to_edge(40);
      check_po_rises("re28");
      check("re28_busy", BUSY, 0);

      // Reset in the middle of a software sequence
      ack_before = ack_cnt;
      step();
      SW_RST_REQ = 1'b1;
      DOMAIN_MASK = 4'b1101;
      step();
      SW_RST_REQ = 1'b0;
      repeat (20) step();
      RST = 1'b1;
      #1;
      check_reset_outputs("rst_sw");
      repeat (2) step();
      RST = 1'b0;
      go_to_edge(40);
      check_po_rises("re_sw");
      check("re_sw_no_ack", ack_cnt, ack_before);

      step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule
